// File: rtl/pwm_deadtime.sv
// Complementary PWM driver: compares an external period counter against a
// double-buffered duty value and drives a high/low switch pair with dead time.
module pwm_deadtime #(
    parameter int unsigned W    = 8,
    parameter int unsigned DT_W = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [W-1:0]    cnt_q,
    input  logic            cnt_rco,
    input  logic            en,
    input  logic [W-1:0]    duty_d,
    input  logic            duty_wr,
    input  logic [DT_W-1:0] dt_d,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic [W-1:0]    duty_act,
    output logic            pending,
    output logic            upd
);

    typedef enum logic [2:0] {
        OFF,
        ON_L,
        DT_RISE,
        ON_H,
        DT_FALL
    } state_t;

    state_t          state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    duty_act_q, duty_act_d;
    logic            pending_q, pending_d;
    logic            upd_q, upd_d;

    logic            pwm_ref;
    logic            dt_zero;
    logic [DT_W-1:0] dt_load;

    assign pwm_ref = (cnt_q < duty_act_q);
    assign dt_zero = (dt_d == '0);
    assign dt_load = dt_d - DT_W'(1);

    // The shadow value held before this edge is what gets applied at RCO;
    // a simultaneous write lands in the shadow and stays pending.
    always_comb begin
        shadow_d   = shadow_q;
        duty_act_d = duty_act_q;
        pending_d  = pending_q;
        upd_d      = 1'b0;
        if (cnt_rco && pending_q) begin
            duty_act_d = shadow_q;
            upd_d      = 1'b1;
            pending_d  = 1'b0;
        end
        if (duty_wr) begin
            shadow_d  = duty_d;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!en) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF, ON_L: begin
                    if (pwm_ref) begin
                        if (dt_zero) begin
                            state_d = ON_H;
                        end else begin
                            state_d  = DT_RISE;
                            dt_cnt_d = dt_load;
                        end
                    end else begin
                        state_d = ON_L;
                    end
                end
                DT_RISE: begin
                    if (!pwm_ref) begin
                        state_d = ON_L;
                    end else if (dt_cnt_q == '0) begin
                        state_d = ON_H;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                ON_H: begin
                    if (!pwm_ref) begin
                        if (dt_zero) begin
                            state_d = ON_L;
                        end else begin
                            state_d  = DT_FALL;
                            dt_cnt_d = dt_load;
                        end
                    end
                end
                DT_FALL: begin
                    if (pwm_ref) begin
                        state_d = ON_H;
                    end else if (dt_cnt_q == '0) begin
                        state_d = ON_L;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= OFF;
            dt_cnt_q   <= '0;
            shadow_q   <= '0;
            duty_act_q <= '0;
            pending_q  <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dt_cnt_q   <= dt_cnt_d;
            shadow_q   <= shadow_d;
            duty_act_q <= duty_act_d;
            pending_q  <= pending_d;
            upd_q      <= upd_d;
        end
    end

    assign pwm_h    = (state_q == ON_H);
    assign pwm_l    = (state_q == ON_L);
    assign duty_act = duty_act_q;
    assign pending  = pending_q;
    assign upd      = upd_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus randomized traffic checked
// against a run-length model of the switch pair and a shadow/active duty model.
module tb_pwm_deadtime;

    localparam int W    = 8;
    localparam int DT_W = 4;
    localparam int TC   = 9;

    logic            clk = 1'b0;
    logic            clr;
    logic [W-1:0]    cnt_q;
    logic            cnt_rco;
    logic            en;
    logic [W-1:0]    duty_d;
    logic            duty_wr;
    logic [DT_W-1:0] dt_d;
    logic            pwm_h, pwm_l, pending, upd;
    logic [W-1:0]    duty_act;

    int vectors     = 0;
    int miscompares = 0;
    int cnt         = 0;

    // model: side 0 = none, 1 = high driven last, 2 = low driven last
    logic [W-1:0] m_shadow, m_act;
    logic         m_pend, m_upd, m_h, m_l;
    int           m_side, m_run, m_run_dt;

    always #5 clk = ~clk;

    pwm_deadtime #(.W(W), .DT_W(DT_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .cnt_q   (cnt_q),
        .cnt_rco (cnt_rco),
        .en      (en),
        .duty_d  (duty_d),
        .duty_wr (duty_wr),
        .dt_d    (dt_d),
        .pwm_h   (pwm_h),
        .pwm_l   (pwm_l),
        .duty_act(duty_act),
        .pending (pending),
        .upd     (upd)
    );

    always @(negedge clk) begin
        vectors++;
        if (pwm_h === 1'b1 && pwm_l === 1'b1) begin
            miscompares++;
            $display("FAIL hl_overlap: got h=%b l=%b, required never both 1", pwm_h, pwm_l);
        end
    end

    task automatic model_reset();
        m_shadow = '0; m_act = '0; m_pend = 0; m_upd = 0;
        m_h = 0; m_l = 0; m_side = 0; m_run = 0; m_run_dt = 0;
    endtask

    // Predict next-cycle outputs from present inputs, then clock once.
    task automatic step();
        logic r;
        int   want;
        if (clr) begin
            model_reset();
        end else begin
            r = (cnt_q < m_act);
            if (!en) begin
                m_side = 0; m_run = 0; m_h = 0; m_l = 0;
            end else begin
                want = r ? 1 : 2;
                if (want == m_side || (m_side == 0 && want == 2)) begin
                    m_side = want; m_run = 0;
                end else begin
                    if (m_run == 0) m_run_dt = int'(dt_d);
                    m_run++;
                    if (m_run >= m_run_dt + 1) begin
                        m_side = want; m_run = 0;
                    end
                end
                m_h = (m_run == 0 && m_side == 1);
                m_l = (m_run == 0 && m_side == 2);
            end
            m_upd = 0;
            if (cnt_rco && m_pend) begin
                m_act = m_shadow; m_upd = 1; m_pend = 0;
            end
            if (duty_wr) begin
                m_shadow = duty_d; m_pend = 1;
            end
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        duty_wr = 1'b0;
        cnt = (cnt == TC) ? 0 : cnt + 1;
        cnt_q = W'(cnt);
        cnt_rco = (cnt == TC);
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 12 && cnt != target; i++) step();
    endtask

    task automatic load_duty(input logic [W-1:0] v);
        if (cnt == TC) step();
        duty_d = v; duty_wr = 1'b1; step();
        wait_cnt(TC);
        step();
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0; dt_d = '0; duty_d = '0; duty_wr = 1'b0;
        step();
        vectors++;
        if ({pwm_h, pwm_l, upd, pending, duty_act} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got h=%b l=%b upd=%b pend=%b act=%0d, required all 0",
                     pwm_h, pwm_l, upd, pending, duty_act);
        end
        en = 1'b1;
        load_duty(8'd255);
        repeat (3) step();
        duty_d = 8'd3; duty_wr = 1'b1; step();
        vectors++;
        if (pwm_h !== 1'b1 || pending !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_clr_setup: got h=%b pend=%b, required h=1 pend=1", pwm_h, pending);
        end
        clr = 1'b1; step();
        vectors++;
        if ({pwm_h, pwm_l, pending, duty_act} !== 11'h000) begin
            miscompares++;
            $display("FAIL clr_from_on_h: got h=%b l=%b pend=%b act=%0d, required all 0",
                     pwm_h, pwm_l, pending, duty_act);
        end
    endtask

    task automatic test_duty_update();
        int nh = 0, nl = 0;
        en = 1'b1; dt_d = '0;
        wait_cnt(4);
        duty_d = 8'd4; duty_wr = 1'b1; step();
        while (cnt != TC) begin
            vectors++;
            if (duty_act !== 8'd0) begin
                miscompares++;
                $display("FAIL duty_held: got act=%0d, required 0", duty_act);
            end
            step();
        end
        step();
        vectors++;
        if (duty_act !== 8'd4 || upd !== 1'b1) begin
            miscompares++;
            $display("FAIL duty_apply: got act=%0d upd=%b, required act=4 upd=1", duty_act, upd);
        end
        step();
        vectors++;
        if (upd !== 1'b0) begin
            miscompares++;
            $display("FAIL upd_pulse: got upd=%b, required 0", upd);
        end
        repeat (10) step();
        for (int i = 0; i < 10; i++) begin
            step();
            nh += int'(pwm_h); nl += int'(pwm_l);
        end
        vectors++;
        if (nh != 4 || nl != 6) begin
            miscompares++;
            $display("FAIL duty4_dt0: got h=%0d l=%0d per period, required h=4 l=6", nh, nl);
        end
    endtask

    task automatic count_period(input string name, input int exp_h, input int exp_l);
        int nh = 0, nl = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nh += int'(pwm_h); nl += int'(pwm_l);
            vectors++;
            if ({pwm_h, pwm_l} !== {m_h, m_l}) begin
                miscompares++;
                $display("FAIL %s_model: got h=%b l=%b, required h=%b l=%b", name, pwm_h, pwm_l, m_h, m_l);
            end
        end
        vectors++;
        if (nh != exp_h || nl != exp_l) begin
            miscompares++;
            $display("FAIL %s_counts: got h=%0d l=%0d, required h=%0d l=%0d", name, nh, nl, exp_h, exp_l);
        end
    endtask

    task automatic test_deadtime();
        dt_d = 4'd2;
        load_duty(8'd5);
        repeat (10) step();
        wait_cnt(0);
        step();
        vectors++;
        if (pwm_l !== 1'b0) begin
            miscompares++;
            $display("FAIL l_fall_after_0: got l=%b, required 0", pwm_l);
        end
        count_period("dt2_duty5", 3, 3);
    endtask

    task automatic test_aborted_rise();
        dt_d = 4'd3;
        load_duty(8'd1);
        repeat (10) step();
        count_period("aborted_rise", 0, 9);
    endtask

    task automatic test_wr_on_rco();
        dt_d = 4'd1;
        wait_cnt(5);
        duty_d = 8'd3; duty_wr = 1'b1; step();
        wait_cnt(TC);
        duty_d = 8'd7; duty_wr = 1'b1; step();
        vectors++;
        if (duty_act !== 8'd3 || upd !== 1'b1 || pending !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_on_rco: got act=%0d upd=%b pend=%b, required act=3 upd=1 pend=1",
                     duty_act, upd, pending);
        end
        wait_cnt(TC);
        step();
        vectors++;
        if (duty_act !== 8'd7 || pending !== 1'b0) begin
            miscompares++;
            $display("FAIL second_rco: got act=%0d pend=%b, required act=7 pend=0", duty_act, pending);
        end
    endtask

    task automatic test_extremes();
        dt_d = 4'd3;
        load_duty(8'd0);
        repeat (10) step();
        count_period("duty0", 0, 10);
        load_duty(8'd255);
        repeat (10) step();
        count_period("duty255", 10, 0);
        en = 1'b0; step();
        vectors++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            miscompares++;
            $display("FAIL en_drop: got h=%b l=%b, required 0 0", pwm_h, pwm_l);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                duty_wr = 1'b1;
                duty_d = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 11) == 0) dt_d = DT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 299) == 0) clr = 1'b1;
            step();
            vectors++;
            if ({pwm_h, pwm_l, upd, pending, duty_act} !== {m_h, m_l, m_upd, m_pend, m_act}) begin
                miscompares++;
                $display("FAIL random_%0d: got h=%b l=%b upd=%b pend=%b act=%0d, required h=%b l=%b upd=%b pend=%b act=%0d",
                         i, pwm_h, pwm_l, upd, pending, duty_act, m_h, m_l, m_upd, m_pend, m_act);
            end
        end
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; duty_d = '0; duty_wr = 1'b0; dt_d = '0;
        cnt = 0; cnt_q = '0; cnt_rco = 1'b0;
        model_reset();
        test_reset();
        test_duty_update();
        test_deadtime();
        test_aborted_rise();
        test_wr_on_rco();
        test_extremes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
